apb_master_param: RTL and testbench

Parametrised second-generation APB master bridging a processor request/response port onto an APB3/APB4 bus with NUM_SLAVES one-hot selects. Adds configurable address/data width, byte strobes, per-slave response muxing, PSLVERR propagation, decode-error and wait-state timeout reporting, and back-to-back transfers without returning to IDLE. Sits between the processor bus and the APB slaves, including the I2C controller.

---
 rtl/apb_pkg.sv | 34 +++
 rtl/apb_master_param_if.sv | 50 +++++
 rtl/apb_rsp_mux.sv | 35 +++
 rtl/apb_master_param.sv | 208 ++++++++++++++++++++
 tb/tb_apb_master_param.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared types and constants for the parametrised APB master.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RSP_OKAY    = 2'd0,
        RSP_SLVERR  = 2'd1,
        RSP_DECERR  = 2'd2,
        RSP_TIMEOUT = 2'd3
    } rsp_err_t;

    localparam logic [1:0] c_rsp_okay    = 2'd0;
    localparam logic [1:0] c_rsp_slverr  = 2'd1;
    localparam logic [1:0] c_rsp_decerr  = 2'd2;
    localparam logic [1:0] c_rsp_timeout = 2'd3;

    // Select-index width; a single slave still needs one bit of index.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_master_param_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_param_if
// Description : Processor request/response port plus APB bus signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_param_if
    import apb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_W      = sel_width(NUM_SLAVES)
);
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_write;
    logic [SEL_W-1:0]           req_sel;
    logic [ADDR_W-1:0]          req_addr;
    logic [DATA_W-1:0]          req_wdata;
    logic [DATA_W/8-1:0]        req_strb;
    logic                       rsp_valid;
    logic [DATA_W-1:0]          rsp_rdata;
    logic [1:0]                 rsp_err;
    logic [NUM_SLAVES-1:0]      psel;
    logic                       penable;
    logic                       pwrite;
    logic [ADDR_W-1:0]          paddr;
    logic [DATA_W-1:0]          pwdata;
    logic [DATA_W/8-1:0]        pstrb;
    logic [NUM_SLAVES*DATA_W-1:0] prdata;
    logic [NUM_SLAVES-1:0]      pready;
    logic [NUM_SLAVES-1:0]      pslverr;

    modport master (
        input  req_valid, req_write, req_sel, req_addr, req_wdata, req_strb,
        input  prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata, pstrb
    );

    modport slave (
        output req_valid, req_write, req_sel, req_addr, req_wdata, req_strb,
        output prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata, pstrb
    );

endinterface
`default_nettype wire

// File: rtl/apb_rsp_mux.sv
`default_nettype none
// ============================================================================
// Module      : apb_rsp_mux
// Description : Selects pready, pslverr and the prdata slice of one slave.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_rsp_mux #(
    parameter int NUM_SLAVES = 4,
    parameter int DATA_W     = 32,
    parameter int SEL_W      = 2
) (
    input  wire logic [SEL_W-1:0]             i_sel,
    input  wire logic [NUM_SLAVES-1:0]        i_pready,
    input  wire logic [NUM_SLAVES-1:0]        i_pslverr,
    input  wire logic [NUM_SLAVES*DATA_W-1:0] i_prdata,
    output logic                              o_pready,
    output logic                              o_pslverr,
    output logic [DATA_W-1:0]                 o_prdata
);

    always_comb begin
        o_pready  = 1'b0;
        o_pslverr = 1'b0;
        o_prdata  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (i_sel == SEL_W'(i)) begin
                o_pready  = i_pready[i];
                o_pslverr = i_pslverr[i];
                o_prdata  = i_prdata[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_master_param.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_param
// Description : Parametrised APB3/APB4 master with one-hot selects, error
//               and timeout reporting, and back-to-back transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_param
    import apb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_W      = sel_width(NUM_SLAVES),
    parameter int TIMEOUT    = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    apb_master_param_if.master bus
);

    localparam int                STRB_W       = DATA_W / 8;
    localparam int                CNT_W        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  c_tmo_last   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [SEL_W:0]    c_num_slaves = (SEL_W + 1)'(NUM_SLAVES);

    state_t                  r_state,     w_state_nxt;
    logic [SEL_W-1:0]        r_sel,       w_sel_nxt;
    logic [NUM_SLAVES-1:0]   r_psel,      w_psel_nxt;
    logic                    r_penable,   w_penable_nxt;
    logic                    r_pwrite,    w_pwrite_nxt;
    logic [ADDR_W-1:0]       r_paddr,     w_paddr_nxt;
    logic [DATA_W-1:0]       r_pwdata,    w_pwdata_nxt;
    logic [STRB_W-1:0]       r_pstrb,     w_pstrb_nxt;
    logic                    r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0]       r_rsp_rdata, w_rsp_rdata_nxt;
    rsp_err_t                r_rsp_err,   w_rsp_err_nxt;
    logic [CNT_W-1:0]        r_cnt,       w_cnt_nxt;
    logic                    r_dec_pend,  w_dec_pend_nxt;

    logic                    w_pready;
    logic                    w_pslverr;
    logic [DATA_W-1:0]       w_prdata;
    logic                    w_req_ready;
    logic                    w_accept;
    logic                    w_dec_err;
    logic                    w_launch;
    logic [NUM_SLAVES-1:0]   w_onehot;

    apb_rsp_mux #(
        .NUM_SLAVES (NUM_SLAVES),
        .DATA_W     (DATA_W),
        .SEL_W      (SEL_W)
    ) u_rsp_mux (
        .i_sel     (r_sel),
        .i_pready  (bus.pready),
        .i_pslverr (bus.pslverr),
        .i_prdata  (bus.prdata),
        .o_pready  (w_pready),
        .o_pslverr (w_pslverr),
        .o_prdata  (w_prdata)
    );

    assign w_req_ready = !reset &&
                         ((r_state == ST_IDLE) || ((r_state == ST_ACCESS) && w_pready));
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_dec_err   = ({1'b0, bus.req_sel} >= c_num_slaves);

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_onehot[i] = (bus.req_sel == SEL_W'(i));
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_pstrb_nxt     = r_pstrb;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_cnt_nxt       = r_cnt;
        w_dec_pend_nxt  = r_dec_pend;
        w_launch        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_launch = w_accept;
            end
            ST_SETUP: begin
                w_state_nxt   = ST_ACCESS;
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
            end
            ST_ACCESS: begin
                if (w_pready) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = r_pwrite ? '0 : w_prdata;
                    w_rsp_err_nxt   = w_pslverr ? RSP_SLVERR : RSP_OKAY;
                    if (w_accept) begin
                        w_launch = 1'b1;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                        w_psel_nxt    = '0;
                        w_penable_nxt = 1'b0;
                    end
                end else if ((TIMEOUT > 0) && (r_cnt == c_tmo_last)) begin
                    w_state_nxt     = ST_IDLE;
                    w_psel_nxt      = '0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = RSP_TIMEOUT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_ERR: begin
                w_state_nxt = ST_IDLE;
                // A decode error accepted alongside a completion reports one cycle late.
                if (r_dec_pend) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = RSP_DECERR;
                    w_dec_pend_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_launch) begin
            if (w_dec_err) begin
                w_state_nxt   = ST_ERR;
                w_psel_nxt    = '0;
                w_penable_nxt = 1'b0;
                if (w_rsp_valid_nxt) begin
                    w_dec_pend_nxt = 1'b1;
                end else begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = RSP_DECERR;
                end
            end else begin
                w_state_nxt   = ST_SETUP;
                w_sel_nxt     = bus.req_sel;
                w_psel_nxt    = w_onehot;
                w_penable_nxt = 1'b0;
                w_pwrite_nxt  = bus.req_write;
                w_paddr_nxt   = bus.req_addr;
                w_pwdata_nxt  = bus.req_wdata;
                w_pstrb_nxt   = bus.req_write ? bus.req_strb : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= RSP_OKAY;
            r_cnt       <= '0;
            r_dec_pend  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_pstrb     <= w_pstrb_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dec_pend  <= w_dec_pend_nxt;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.pstrb     = r_pstrb;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_param
// Description : Self-checking bench for apb_master_param (NUM_SLAVES=4, SEL_W=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_param;
    import apb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int NSL    = 4;
    localparam int SELW   = 3;
    localparam int TMO    = 16;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic [1:0]        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t sb_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_mis = 0;

    apb_master_param_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NSL), .SEL_W(SELW)) bus ();

    apb_master_param #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NSL), .SEL_W(SELW), .TIMEOUT(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic wr, input logic [SELW-1:0] sel,
                             input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                             input logic [DATA_W/8-1:0] strb);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_sel   = sel;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_strb  = strb;
    endtask

    task automatic wait_rsp(input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (bus.rsp_valid) begin
                seen = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        tick(); tick();
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_mis++; $display("FAIL reset_req_ready got=%b exp=0", bus.req_ready); end
        n_cmp++; if (bus.psel !== 4'b0000 || bus.penable !== 1'b0) begin n_mis++; $display("FAIL reset_psel got=%b/%b exp=0000/0", bus.psel, bus.penable); end
        n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 2'd0 || bus.rsp_rdata !== '0) begin n_mis++; $display("FAIL reset_rsp got=%b/%0d/%h exp=0/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
        n_cmp++; if (bus.paddr !== '0 || bus.pwdata !== '0 || bus.pstrb !== '0 || bus.pwrite !== 1'b0) begin n_mis++; $display("FAIL reset_bus got=%h/%h/%h/%b exp=0", bus.paddr, bus.pwdata, bus.pstrb, bus.pwrite); end
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_mis++; $display("FAIL idle_req_ready got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_zero_wait_write;
        bit seen;
        bus.pready  = 4'b1110;   // unselected slave 0 stalls and errors: must be ignored
        bus.pslverr = 4'b0001;
        drive_req(1'b1, 3'd1, 32'h10, 32'hA5A5_0001, 4'hF);
        sb_q.push_back('{rdata: '0, err: c_rsp_okay});
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_mis++; $display("FAIL zw_accept got=%b exp=1", bus.req_ready); end
        tick();
        bus.req_valid = 1'b0;
        n_cmp++; if (bus.psel !== 4'b0010 || bus.penable !== 1'b0) begin n_mis++; $display("FAIL zw_setup psel/pen got=%b/%b exp=0010/0", bus.psel, bus.penable); end
        n_cmp++; if (bus.paddr !== 32'h10 || bus.pwdata !== 32'hA5A5_0001 || bus.pstrb !== 4'hF || bus.pwrite !== 1'b1) begin n_mis++; $display("FAIL zw_setup_bus got=%h/%h/%h/%b exp=10/a5a50001/f/1", bus.paddr, bus.pwdata, bus.pstrb, bus.pwrite); end
        tick();
        n_cmp++; if (bus.psel !== 4'b0010 || bus.penable !== 1'b1 || bus.pstrb !== 4'hF) begin n_mis++; $display("FAIL zw_access got=%b/%b/%h exp=0010/1/f", bus.psel, bus.penable, bus.pstrb); end
        tick();
        seen = bus.rsp_valid;
        n_cmp++; if (seen !== 1'b1) begin n_mis++; $display("FAIL zw_rsp_latency got=%b exp=1", seen); end
        e = sb_q.pop_front();
        n_cmp++; if ({bus.rsp_rdata, bus.rsp_err} !== {e.rdata, e.err}) begin n_mis++; $display("FAIL zw_rsp got=%h/%0d exp=%h/%0d", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err); end
        n_cmp++; if (bus.psel !== 4'b0000 || bus.penable !== 1'b0) begin n_mis++; $display("FAIL zw_idle got=%b/%b exp=0000/0", bus.psel, bus.penable); end
        tick();
        n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.paddr !== 32'h10 || bus.pwdata !== 32'hA5A5_0001) begin n_mis++; $display("FAIL zw_hold got=%b/%h/%h exp=0/10/a5a50001", bus.rsp_valid, bus.paddr, bus.pwdata); end
        bus.pready  = 4'b1111;
        bus.pslverr = 4'b0000;
    endtask

    task automatic test_wait_read;
        int  pen_cnt = 0;
        bit  seen = 1'b0;
        bit  strb_bad = 1'b0;
        bus.pready = 4'b1011;
        bus.prdata = {32'hDEAD_0003, 32'h1234_5678, 32'hDEAD_0001, 32'hDEAD_0000};
        drive_req(1'b0, 3'd2, 32'h20, 32'hFFFF_FFFF, 4'hF);
        sb_q.push_back('{rdata: 32'h1234_5678, err: c_rsp_okay});
        tick();
        bus.req_valid = 1'b0;
        n_cmp++; if (bus.psel !== 4'b0100 || bus.pstrb !== 4'h0 || bus.pwrite !== 1'b0) begin n_mis++; $display("FAIL wr_setup got=%b/%h/%b exp=0100/0/0", bus.psel, bus.pstrb, bus.pwrite); end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.rsp_valid) begin seen = 1'b1; break; end
            if (bus.penable) begin
                pen_cnt++;
                if (bus.pstrb !== 4'h0) strb_bad = 1'b1;
            end
            bus.pready[2] = (pen_cnt == 4);
        end
        n_cmp++; if (pen_cnt != 4 || !seen) begin n_mis++; $display("FAIL wr_penable_cycles got=%0d seen=%b exp=4 seen=1", pen_cnt, seen); end
        n_cmp++; if (strb_bad) begin n_mis++; $display("FAIL wr_pstrb got=nonzero exp=0"); end
        e = sb_q.pop_front();
        n_cmp++; if ({bus.rsp_rdata, bus.rsp_err} !== {e.rdata, e.err}) begin n_mis++; $display("FAIL wr_rsp got=%h/%0d exp=%h/%0d", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err); end
        bus.pready = 4'b1111;
        tick();
    endtask

    task automatic test_back_to_back;
        bus.pready = 4'b1111;
        bus.prdata[3*DATA_W +: DATA_W] = 32'hCAFE_0003;
        drive_req(1'b1, 3'd0, 32'h40, 32'h1111_2222, 4'b0011);
        sb_q.push_back('{rdata: '0, err: c_rsp_okay});
        tick();
        drive_req(1'b0, 3'd3, 32'h80, 32'h0, 4'hF);
        sb_q.push_back('{rdata: 32'hCAFE_0003, err: c_rsp_okay});
        #1;
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_mis++; $display("FAIL b2b_setup_ready got=%b exp=0", bus.req_ready); end
        tick();
        n_cmp++; if (bus.psel !== 4'b0001 || bus.penable !== 1'b1 || bus.req_ready !== 1'b1) begin n_mis++; $display("FAIL b2b_access_a got=%b/%b/%b exp=0001/1/1", bus.psel, bus.penable, bus.req_ready); end
        tick();
        bus.req_valid = 1'b0;
        e = sb_q.pop_front();
        n_cmp++; if (bus.rsp_valid !== 1'b1 || {bus.rsp_rdata, bus.rsp_err} !== {e.rdata, e.err}) begin n_mis++; $display("FAIL b2b_rsp_a got=%b/%h/%0d exp=1/%h/%0d", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err); end
        n_cmp++; if (bus.psel !== 4'b1000 || bus.penable !== 1'b0 || bus.paddr !== 32'h80 || bus.pstrb !== 4'h0) begin n_mis++; $display("FAIL b2b_setup_b got=%b/%b/%h/%h exp=1000/0/80/0", bus.psel, bus.penable, bus.paddr, bus.pstrb); end
        tick();
        n_cmp++; if (bus.psel !== 4'b1000 || bus.penable !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_mis++; $display("FAIL b2b_access_b got=%b/%b/%b exp=1000/1/0", bus.psel, bus.penable, bus.rsp_valid); end
        tick();
        e = sb_q.pop_front();
        n_cmp++; if (bus.rsp_valid !== 1'b1 || {bus.rsp_rdata, bus.rsp_err} !== {e.rdata, e.err}) begin n_mis++; $display("FAIL b2b_rsp_b got=%b/%h/%0d exp=1/%h/%0d", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err); end
        n_cmp++; if (bus.psel !== 4'b0000) begin n_mis++; $display("FAIL b2b_idle got=%b exp=0000", bus.psel); end
        tick();
    endtask

    task automatic test_timeout;
        for (int run = 0; run < 2; run++) begin
            int pen_cnt = 0;
            bit seen = 1'b0;
            bus.pready = 4'b1110;
            bus.prdata[0 +: DATA_W] = 32'h0BAD_0000;
            drive_req(1'b0, 3'd0, 32'hC0, 32'h0, 4'h0);
            if (run == 0) sb_q.push_back('{rdata: '0, err: c_rsp_timeout});
            else          sb_q.push_back('{rdata: 32'h0BAD_0000, err: c_rsp_okay});
            tick();
            bus.req_valid = 1'b0;
            for (int k = 0; k < 40; k++) begin
                tick();
                if (bus.rsp_valid) begin seen = 1'b1; break; end
                if (bus.penable) pen_cnt++;
                if (run == 1) bus.pready[0] = (pen_cnt == TMO);
            end
            n_cmp++; if (pen_cnt != TMO || !seen) begin n_mis++; $display("FAIL tmo_cycles run%0d got=%0d seen=%b exp=%0d seen=1", run, pen_cnt, seen, TMO); end
            e = sb_q.pop_front();
            n_cmp++; if ({bus.rsp_rdata, bus.rsp_err} !== {e.rdata, e.err} || bus.psel !== 4'b0000 || bus.penable !== 1'b0) begin n_mis++; $display("FAIL tmo_rsp run%0d got=%h/%0d/%b exp=%h/%0d/0000", run, bus.rsp_rdata, bus.rsp_err, bus.psel, e.rdata, e.err); end
            bus.pready = 4'b1111;
            tick();
        end
    endtask

    task automatic test_slverr;
        bit seen;
        bus.pready  = 4'b1111;
        bus.pslverr = 4'b0010;
        bus.prdata[1*DATA_W +: DATA_W] = 32'h55AA_55AA;
        drive_req(1'b0, 3'd1, 32'h08, 32'h0, 4'h0);
        sb_q.push_back('{rdata: 32'h55AA_55AA, err: c_rsp_slverr});
        tick();
        bus.req_valid = 1'b0;
        wait_rsp(10, seen);
        e = sb_q.pop_front();
        n_cmp++; if (!seen || {bus.rsp_rdata, bus.rsp_err} !== {e.rdata, e.err}) begin n_mis++; $display("FAIL slverr_rsp got=%b/%h/%0d exp=1/%h/%0d", seen, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err); end
        bus.pslverr = 4'b0000;
        tick();
    endtask

    task automatic test_decerr;
        drive_req(1'b1, 3'd5, 32'h50, 32'h1, 4'hF);
        sb_q.push_back('{rdata: '0, err: c_rsp_decerr});
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_mis++; $display("FAIL dec_accept got=%b exp=1", bus.req_ready); end
        tick();
        bus.req_valid = 1'b0;
        n_cmp++; if (bus.psel !== 4'b0000 || bus.penable !== 1'b0) begin n_mis++; $display("FAIL dec_psel got=%b/%b exp=0000/0", bus.psel, bus.penable); end
        e = sb_q.pop_front();
        n_cmp++; if (bus.rsp_valid !== 1'b1 || {bus.rsp_rdata, bus.rsp_err} !== {e.rdata, e.err}) begin n_mis++; $display("FAIL dec_rsp got=%b/%h/%0d exp=1/%h/%0d", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err); end
        tick();
        n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.psel !== 4'b0000) begin n_mis++; $display("FAIL dec_after got=%b/%b exp=0/0000", bus.rsp_valid, bus.psel); end
    endtask

    task automatic test_reset_mid;
        bit seen;
        bit stray = 1'b0;
        bus.pready = 4'b1011;
        drive_req(1'b0, 3'd2, 32'h70, 32'h0, 4'h0);
        tick();
        bus.req_valid = 1'b0;
        tick();
        n_cmp++; if (bus.penable !== 1'b1 || bus.psel !== 4'b0100) begin n_mis++; $display("FAIL rm_in_access got=%b/%b exp=1/0100", bus.penable, bus.psel); end
        reset = 1'b1;
        tick();
        n_cmp++; if (bus.psel !== 4'b0000 || bus.penable !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_mis++; $display("FAIL rm_abort got=%b/%b/%b exp=0000/0/0", bus.psel, bus.penable, bus.rsp_valid); end
        reset = 1'b0;
        bus.pready = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.rsp_valid) stray = 1'b1;
        end
        n_cmp++; if (stray) begin n_mis++; $display("FAIL rm_no_rsp got=rsp_valid exp=none"); end
        drive_req(1'b1, 3'd2, 32'h74, 32'hBEEF_0002, 4'hC);
        sb_q.push_back('{rdata: '0, err: c_rsp_okay});
        tick();
        bus.req_valid = 1'b0;
        wait_rsp(10, seen);
        e = sb_q.pop_front();
        n_cmp++; if (!seen || {bus.rsp_rdata, bus.rsp_err} !== {e.rdata, e.err}) begin n_mis++; $display("FAIL rm_fresh got=%b/%h/%0d exp=1/%h/%0d", seen, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err); end
        tick();
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_sel   = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_strb  = '0;
        bus.prdata    = '0;
        bus.pready    = 4'b1111;
        bus.pslverr   = 4'b0000;

        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_back_to_back();
        test_timeout();
        test_slverr();
        test_decerr();
        test_reset_mid();

        n_cmp++; if (sb_q.size() != 0) begin n_mis++; $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=stuck exp=finish");
        $fatal(1, "bench time limit exceeded");
    end

endmodule
`default_nettype wire
